board_win_scanner: RTL and testbench



---
 rtl/board_win_scanner_if.sv | 26 ++
 rtl/board_win_scanner.sv | 152 +++++++++++++++
 tb/tb_board_win_scanner.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/board_win_scanner_if.sv
// Handshake and result bundle between the win scanner and its users
// (game-control FSM drives the request side, display logic reads results).
interface board_win_scanner_if;
  logic        start;
  logic [15:0] in_gameboard;
  logic [15:0] in_players_cells;
  logic        busy;
  logic        done;
  logic        win_valid;
  logic        winner;
  logic [3:0]  win_line;
  logic [15:0] win_cells;
  logic        draw;

  // Requester: issues start and presents the board
  modport master (
    output start, in_gameboard, in_players_cells,
    input  busy, done, win_valid, winner, win_line, win_cells, draw
  );

  // Scanner: samples the board and reports results
  modport slave (
    input  start, in_gameboard, in_players_cells,
    output busy, done, win_valid, winner, win_line, win_cells, draw
  );
endinterface

// File: rtl/board_win_scanner.sv
// Connect4 4x4 win scanner: snapshots the board on start, then tests one
// of the 10 four-in-a-row lines per clock and reports winner/line/draw.
module board_win_scanner #(
  parameter bit STOP_EARLY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  board_win_scanner_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  localparam logic [3:0] LAST_LINE = 4'd9;

  state_t      state_q, state_d;
  logic [3:0]  line_q, line_d;
  logic [15:0] snap_board_q, snap_board_d;
  logic [15:0] snap_players_q, snap_players_d;
  logic        win_valid_q, win_valid_d;
  logic        winner_q, winner_d;
  logic [3:0]  win_line_q, win_line_d;
  logic [15:0] win_cells_q, win_cells_d;
  logic        draw_q, draw_d;

  logic [15:0] line_mask;
  logic [15:0] owned_bits;
  logic        line_full;
  logic        line_wins;

  // Cell mask of line idx; cell index is row*4 + col, row 0 at the bottom.
  function automatic logic [15:0] mask_of_line(input logic [3:0] idx);
    logic [15:0] m;
    m = 16'h0000;
    case (idx)
      4'd0:    m = 16'h000F;
      4'd1:    m = 16'h00F0;
      4'd2:    m = 16'h0F00;
      4'd3:    m = 16'hF000;
      4'd4:    m = 16'h1111;
      4'd5:    m = 16'h2222;
      4'd6:    m = 16'h4444;
      4'd7:    m = 16'h8888;
      4'd8:    m = 16'h8421;
      4'd9:    m = 16'h1248;
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  // Evaluate the current line against the snapshot only
  always_comb begin
    line_mask  = mask_of_line(line_q);
    owned_bits = snap_players_q & line_mask;
    line_full  = ((snap_board_q & line_mask) == line_mask);
    line_wins  = line_full && ((owned_bits == line_mask) || (owned_bits == 16'h0000));
  end

  // Next-state and result update for IDLE -> SCAN -> REPORT -> IDLE
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d        = state_q;
    line_d         = line_q;
    snap_board_d   = snap_board_q;
    snap_players_d = snap_players_q;
    win_valid_d    = win_valid_q;
    winner_d       = winner_q;
    win_line_d     = win_line_q;
    win_cells_d    = win_cells_q;
    draw_d         = draw_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_board_d   = bus.in_gameboard;
          snap_players_d = bus.in_players_cells;
          win_valid_d    = 1'b0;
          winner_d       = 1'b0;
          win_line_d     = 4'd0;
          win_cells_d    = 16'h0000;
          draw_d         = 1'b0;
          line_d         = 4'd0;
          state_d        = SCAN;
        end
      end

      SCAN: begin
        // Only the first (lowest-index) winning line is recorded
        if (line_wins && !win_valid_q) begin
          win_valid_d = 1'b1;
          winner_d    = |owned_bits;
          win_line_d  = line_q;
          win_cells_d = line_mask;
        end
        if ((STOP_EARLY && line_wins) || (line_q == LAST_LINE)) begin
          draw_d  = ~win_valid_d & (&snap_board_q);
          state_d = REPORT;
        end else begin
          line_d = line_q + 4'd1;
        end
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, snapshot and result registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the snapshot registers are reset too; they are few flops and
      // this keeps every output deterministic right after reset.
      state_q        <= IDLE;
      line_q         <= 4'd0;
      snap_board_q   <= 16'h0000;
      snap_players_q <= 16'h0000;
      win_valid_q    <= 1'b0;
      winner_q       <= 1'b0;
      win_line_q     <= 4'd0;
      win_cells_q    <= 16'h0000;
      draw_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      line_q         <= line_d;
      snap_board_q   <= snap_board_d;
      snap_players_q <= snap_players_d;
      win_valid_q    <= win_valid_d;
      winner_q       <= winner_d;
      win_line_q     <= win_line_d;
      win_cells_q    <= win_cells_d;
      draw_q         <= draw_d;
    end
  end

  // Status is decoded straight from state; results come from registers
  always_comb begin
    bus.busy      = (state_q == SCAN);
    bus.done      = (state_q == REPORT);
    bus.win_valid = win_valid_q;
    bus.winner    = winner_q;
    bus.win_line  = win_line_q;
    bus.win_cells = win_cells_q;
    bus.draw      = draw_q;
  end

endmodule

// File: tb/tb_board_win_scanner.sv
// Self-checking bench: two scanners (STOP_EARLY=0 and =1) driven with the
// same stimulus, each compared every cycle against a line-table model.
module tb_board_win_scanner;

  logic clk;
  logic reset;

  board_win_scanner_if if0 ();
  board_win_scanner_if if1 ();

  board_win_scanner #(.STOP_EARLY(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  board_win_scanner #(.STOP_EARLY(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the lines from their geometric definition and return
  // the lowest-index line whose four cells are occupied by one owner.
  task automatic golden(input logic [15:0] b, input logic [15:0] p,
                        output logic win, output logic who,
                        output logic [3:0] line, output logic [15:0] cells);
    win = 1'b0; who = 1'b0; line = 4'd0; cells = 16'h0;
    for (int l = 0; l < 10; l++) begin
      int r, c, idx, occ, ones;
      logic [15:0] m;
      m = 16'h0; occ = 0; ones = 0;
      for (int i = 0; i < 4; i++) begin
        if (l < 4)       begin r = l; c = i; end
        else if (l < 8)  begin r = i; c = l - 4; end
        else if (l == 8) begin r = i; c = i; end
        else             begin r = i; c = 3 - i; end
        idx = r * 4 + c;
        m[idx] = 1'b1;
        occ  += int'(b[idx]);
        ones += int'(p[idx]);
      end
      if (!win && occ == 4 && (ones == 0 || ones == 4)) begin
        win = 1'b1; who = (ones == 4); line = 4'(l); cells = m;
      end
    end
  endtask

  // Model state per instance: [0] = STOP_EARLY 0, [1] = STOP_EARLY 1
  int          busy_left [2];
  logic        rep       [2];
  logic        e_valid   [2], e_winner [2], e_draw [2];
  logic [3:0]  e_line    [2];
  logic [15:0] e_cells   [2];
  logic        p_valid   [2], p_winner [2], p_draw [2];
  logic [3:0]  p_line    [2];
  logic [15:0] p_cells   [2];

  // Model advance: one transaction = accept, scan for L cycles, one report cycle
  always @(posedge clk or posedge reset) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        busy_left[m] = 0; rep[m] = 1'b0;
        e_valid[m] = 1'b0; e_winner[m] = 1'b0; e_line[m] = 4'd0;
        e_cells[m] = 16'h0; e_draw[m] = 1'b0;
      end else if (rep[m]) begin
        rep[m] = 1'b0;
      end else if (busy_left[m] > 0) begin
        busy_left[m]--;
        if (busy_left[m] == 0) begin
          rep[m] = 1'b1;
          e_valid[m] = p_valid[m]; e_winner[m] = p_winner[m];
          e_line[m] = p_line[m]; e_cells[m] = p_cells[m]; e_draw[m] = p_draw[m];
        end
      end else if (if0.start) begin
        golden(if0.in_gameboard, if0.in_players_cells, p_valid[m], p_winner[m], p_line[m], p_cells[m]);
        p_draw[m] = !p_valid[m] && (if0.in_gameboard == 16'hFFFF);
        busy_left[m] = (m == 1 && p_valid[m]) ? int'(p_line[m]) + 1 : 10;
        e_valid[m] = 1'b0; e_winner[m] = 1'b0; e_line[m] = 4'd0;
        e_cells[m] = 16'h0; e_draw[m] = 1'b0;
      end
    end
  end

  // Per-cycle comparison; results only while no scan is running
  always @(negedge clk) begin
    check("u0.busy", 32'(if0.busy), 32'(busy_left[0] > 0));
    check("u0.done", 32'(if0.done), 32'(rep[0]));
    check("u1.busy", 32'(if1.busy), 32'(busy_left[1] > 0));
    check("u1.done", 32'(if1.done), 32'(rep[1]));
    if (busy_left[0] == 0) begin
      check("u0.win_valid", 32'(if0.win_valid), 32'(e_valid[0]));
      check("u0.winner",    32'(if0.winner),    32'(e_winner[0]));
      check("u0.win_line",  32'(if0.win_line),  32'(e_line[0]));
      check("u0.win_cells", 32'(if0.win_cells), 32'(e_cells[0]));
      check("u0.draw",      32'(if0.draw),      32'(e_draw[0]));
    end
    if (busy_left[1] == 0) begin
      check("u1.win_valid", 32'(if1.win_valid), 32'(e_valid[1]));
      check("u1.winner",    32'(if1.winner),    32'(e_winner[1]));
      check("u1.win_line",  32'(if1.win_line),  32'(e_line[1]));
      check("u1.win_cells", 32'(if1.win_cells), 32'(e_cells[1]));
      check("u1.draw",      32'(if1.draw),      32'(e_draw[1]));
    end
  end

  task automatic drive(input logic s, input logic [15:0] b, input logic [15:0] p);
    if0.start = s; if0.in_gameboard = b; if0.in_players_cells = p;
    if1.start = s; if1.in_gameboard = b; if1.in_players_cells = p;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".u0_outs"}, {if0.busy, if0.done, if0.win_valid, if0.winner, if0.draw, if0.win_line, if0.win_cells}, 32'h0);
    check({tag, ".u1_outs"}, {if1.busy, if1.done, if1.win_valid, if1.winner, if1.draw, if1.win_line, if1.win_cells}, 32'h0);
  endtask

  // Directed scan: pulse start, measure done delay per instance (in cycles
  // after the start-driving edge) and check the literal result.
  task automatic run_scan(input string nm, input logic [15:0] b, input logic [15:0] p,
                          input logic clear_after, input int lat0, input int lat1,
                          input logic x_valid, input logic x_winner, input logic [3:0] x_line,
                          input logic [15:0] x_cells, input logic x_draw);
    int seen0, seen1;
    @(negedge clk);
    drive(1'b1, b, p);
    seen0 = 0; seen1 = 0;
    for (int n = 1; n <= 25 && (seen0 == 0 || seen1 == 0); n++) begin
      @(negedge clk);
      drive(1'b0, clear_after ? 16'h0 : b, clear_after ? 16'h0 : p);
      if (seen0 == 0 && if0.done) seen0 = n;
      if (seen1 == 0 && if1.done) seen1 = n;
    end
    check({nm, ".u0_latency"}, 32'(seen0), 32'(lat0 + 1));
    check({nm, ".u1_latency"}, 32'(seen1), 32'(lat1 + 1));
    check({nm, ".u1_result"}, {if1.win_valid, if1.winner, if1.draw, 5'd0, if1.win_line, 8'd0, if1.win_cells},
          {x_valid, x_winner, x_draw, 5'd0, x_line, 8'd0, x_cells});
    check({nm, ".u0_result"}, {if0.win_valid, if0.winner, if0.draw, 5'd0, if0.win_line, 8'd0, if0.win_cells},
          {x_valid, x_winner, x_draw, 5'd0, x_line, 8'd0, x_cells});
    @(negedge clk);
  endtask

  initial begin
    logic        gw, gwho;
    logic [3:0]  gl;
    logic [15:0] gc;
    int          dn0, dn1;

    reset = 1'b0;
    drive(1'b0, 16'h0, 16'h0);
    #1 reset = 1'b1;

    // Pin the reference model to hand-derived results
    golden(16'h000F, 16'h0000, gw, gwho, gl, gc);
    check("model.row0", {gw, gwho, gl, gc}, {1'b1, 1'b0, 4'd0, 16'h000F});
    golden(16'h1111, 16'h1111, gw, gwho, gl, gc);
    check("model.col0", {gw, gwho, gl, gc}, {1'b1, 1'b1, 4'd4, 16'h1111});
    golden(16'h1248, 16'h1248, gw, gwho, gl, gc);
    check("model.diag9", {gw, gwho, gl, gc}, {1'b1, 1'b1, 4'd9, 16'h1248});
    golden(16'hFFFF, 16'h3CC3, gw, gwho, gl, gc);
    check("model.nowin", 32'(gw), 32'(0));
    golden(16'h7FFF, 16'h8000, gw, gwho, gl, gc);
    check("model.row3_unoccupied", 32'(gw), 32'(1));
    check("model.row3_unoccupied_line", 32'(gl), 32'(0));

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;

    run_scan("empty",   16'h0000, 16'h0000, 1'b0, 10, 10, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    run_scan("row0",    16'h000F, 16'h0000, 1'b0, 10,  1, 1'b1, 1'b0, 4'd0, 16'h000F, 1'b0);
    run_scan("col0",    16'h1111, 16'h1111, 1'b0, 10,  5, 1'b1, 1'b1, 4'd4, 16'h1111, 1'b0);
    run_scan("diag9",   16'h1248, 16'h1248, 1'b0, 10, 10, 1'b1, 1'b1, 4'd9, 16'h1248, 1'b0);
    run_scan("full",    16'hFFFF, 16'h3CC3, 1'b0, 10, 10, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    run_scan("snap",    16'h00F0, 16'h00F0, 1'b1, 10,  2, 1'b1, 1'b1, 4'd1, 16'h00F0, 1'b0);
    run_scan("two_win", 16'hFF00, 16'hF000, 1'b0, 10,  3, 1'b1, 1'b0, 4'd2, 16'h0F00, 1'b0);

    // Start held high: one scan per IDLE pass, 12 cycles apart
    @(negedge clk);
    drive(1'b1, 16'hFFFF, 16'h3CC3);
    dn0 = 0; dn1 = 0;
    for (int n = 1; n <= 48; n++) begin
      @(negedge clk);
      dn0 += int'(if0.done);
      dn1 += int'(if1.done);
    end
    drive(1'b0, 16'hFFFF, 16'h3CC3);
    check("held_start.u0_scans", 32'(dn0), 32'd4);
    check("held_start.u1_scans", 32'(dn1), 32'd4);
    repeat (2) @(negedge clk);

    // Reset on scan cycle 3: outputs clear at once, no done pulse follows
    @(negedge clk);
    drive(1'b1, 16'hFFFF, 16'h0000);
    @(negedge clk);
    drive(1'b0, 16'hFFFF, 16'h0000);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero_outputs("mid_reset");
    dn0 = 0; dn1 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      dn0 += int'(if0.done);
      dn1 += int'(if1.done);
    end
    check("mid_reset.no_done", 32'(dn0 + dn1), 32'd0);
    run_scan("after_reset", 16'h8888, 16'h0000, 1'b0, 10, 8, 1'b1, 1'b0, 4'd7, 16'h8888, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] b, p;
      @(negedge clk);
      if (reset) reset = 1'b0;
      b = 16'($urandom) | 16'($urandom);
      case ($urandom_range(0, 3))
        0:       p = 16'h0000;
        1:       p = 16'hFFFF;
        default: p = 16'($urandom);
      endcase
      drive($urandom_range(0, 3) == 0, b, p);
      if ($urandom_range(0, 499) == 0) #2 reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
